rgb_capture: RTL

- Receiver side of the parallel RGB565 LCD interface (HSYNC/VSYNC/DEN plus 5/6/5 colour) driven by the display pipeline.
- Recovers pixel and line coordinates from DEN and VSYNC, and measures active width/height with a lock flag.
- On request, captures one frame: decimates 2:1 in x and y and writes 16-bit pixels into a 32K-word frame buffer at address {y[7:1], x[8:1]}, the same layout the display ROM is read with.
- Used for loopback test of the video chain and for frame grabbing.

---
 rtl/rgb_capture.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rgb_capture.sv
// RGB565 parallel-LCD receiver: recovers pixel/line position from DEN and VSYNC, measures
// the active geometry, and grabs one 2:1-decimated frame into a 32K-word buffer on request.
module rgb_capture #(
    parameter int HS_POL = 0,
    parameter int VS_POL = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic        i_den,
    input  logic [4:0]  i_r,
    input  logic [5:0]  i_g,
    input  logic [4:0]  i_b,
    input  logic        i_arm,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_wr_en,
    output logic [14:0] o_wr_addr,
    output logic [15:0] o_wr_data,
    output logic [9:0]  o_h_active,
    output logic [9:0]  o_v_active,
    output logic        o_locked
);

    localparam logic HS_LVL = (HS_POL != 0);
    localparam logic VS_LVL = (VS_POL != 0);

    typedef enum logic [1:0] {IDLE, ARMED, CAPT} state_t;

    state_t      state, state_next;
    logic        done_next;
    logic        vs_act, vs_act_d, den_q, den_d, arm_q;
    logic [4:0]  r_q;
    logic [5:0]  g_q;
    logic [4:0]  b_q;
    logic [9:0]  x_cnt, y_cnt;
    logic        seen_vs, h_changed;
    logic        vs_start, den_fall, wr_next;

    // DEN alone delimits lines, so hsync carries no information this block needs.
    logic unused_hsync;
    assign unused_hsync = i_hsync ^ HS_LVL;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vs_act   <= 1'b0;
            vs_act_d <= 1'b0;
            den_q    <= 1'b0;
            den_d    <= 1'b0;
            arm_q    <= 1'b0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
        end else begin
            vs_act   <= (i_vsync == VS_LVL);
            vs_act_d <= vs_act;
            den_q    <= i_den;
            den_d    <= den_q;
            arm_q    <= i_arm;
            r_q      <= i_r;
            g_q      <= i_g;
            b_q      <= i_b;
        end
    end

    assign vs_start = vs_act & ~vs_act_d;
    assign den_fall = den_d & ~den_q;

    // While a pixel sits in the input register, x_cnt is its index within the line.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            if (den_fall)
                x_cnt <= '0;
            else if (den_q && x_cnt != 10'd1023)
                x_cnt <= x_cnt + 10'd1;

            if (vs_start)
                y_cnt <= '0;
            else if (den_fall && y_cnt != 10'd1023)
                y_cnt <= y_cnt + 10'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_h_active <= '0;
            o_v_active <= '0;
            o_locked   <= 1'b0;
            seen_vs    <= 1'b0;
            h_changed  <= 1'b0;
        end else begin
            if (den_fall)
                o_h_active <= x_cnt;

            if (vs_start)
                h_changed <= 1'b0;
            else if (den_fall && x_cnt != o_h_active)
                h_changed <= 1'b1;

            if (vs_start) begin
                o_v_active <= y_cnt;
                o_locked   <= seen_vs && (y_cnt == o_v_active) && (y_cnt != 10'd0) && !h_changed;
                seen_vs    <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            state  <= state_next;
            o_busy <= (state_next != IDLE);
            o_done <= done_next;
        end
    end

    // An arm landing together with a frame start only arms; capture waits for the next one.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE:    if (arm_q) state_next = ARMED;
            ARMED:   if (vs_start) state_next = CAPT;
            CAPT: begin
                if (vs_start) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign wr_next = (state == CAPT) && !vs_start && den_q && !x_cnt[0] && !y_cnt[0]
                     && !x_cnt[9] && (y_cnt[9:8] == 2'b00);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
        end else begin
            o_wr_en <= wr_next;
            if (wr_next) begin
                o_wr_addr <= {y_cnt[7:1], x_cnt[8:1]};
                o_wr_data <= {r_q, g_q, b_q};
            end
        end
    end

endmodule
